// File: rtl/sprite_fetch_pkg.sv
// Shared constants and state type for the sprite fetch arbiter.
package sprite_fetch_pkg;

    localparam int ROM_ADDR_W = 8;
    localparam int ROM_DATA_W = 16;
    localparam int ROM_DEPTH  = 256;

    typedef enum logic {
        IDLE,
        BURST
    } fetch_state_t;

endpackage

// File: rtl/sprite_rr_pick.sv
// Combinational winner selection for the sprite fetch arbiter.
// Defining SPRITE_FETCH_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module sprite_rr_pick
    import sprite_fetch_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   winner_o
);

    assign any_o = |req_i;

`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    logic unusedPtr;
    assign unusedPtr = ^ptr_i;

    always_comb begin
        winner_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[IDX_W'(i)]) begin
                winner_o = IDX_W'(i);
            end
        end
    end
`else
    logic found;
    int   idx;

    // The scan starts one past the previous winner so nobody can starve.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[IDX_W'(idx)]) begin
                winner_o = IDX_W'(idx);
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares one registered-read sprite ROM between NUM_REQ requesters as fixed-length bursts.
// Define SPRITE_FETCH_FIXED_PRIO_EN for fixed priority instead of round-robin arbitration.
module sprite_fetch_arbiter
    import sprite_fetch_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int BURST_LEN = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*8-1:0]    req_addr,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [ROM_ADDR_W-1:0]   rom_addr,
    input  logic [ROM_DATA_W-1:0]   rom_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [ROM_DATA_W-1:0]   rsp_data,
    output logic                    rsp_last,
    output logic                    busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    fetch_state_t            state_q;
    logic [IDX_W-1:0]        owner_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [NUM_REQ-1:0]      gnt_q;
    logic [ROM_ADDR_W-1:0]   romAddr_q;
    logic [NUM_REQ-1:0]      rspValid_q;
    logic                    rspLast_q;

    logic                    pickAny;
    logic [IDX_W-1:0]        pickWin;
    logic [IDX_W-1:0]        lastWin;

    sprite_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (lastWin),
        .any_o    (pickAny),
        .winner_o (pickWin)
    );

`ifdef SPRITE_FETCH_FIXED_PRIO_EN
    assign lastWin = '0;
`else
    logic [IDX_W-1:0] lastWin_q;

    // Resetting to the top index makes requester 0 the first winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastWin_q <= IDX_W'(NUM_REQ - 1);
        end else if (state_q == IDLE && pickAny) begin
            lastWin_q <= pickWin;
        end
    end

    assign lastWin = lastWin_q;
`endif

    // rspValid_q/rspLast_q trail the address by one cycle to line up with the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_q     <= '0;
            gnt_q      <= '0;
            romAddr_q  <= '0;
            rspValid_q <= '0;
            rspLast_q  <= 1'b0;
        end else begin
            rspValid_q <= '0;
            rspLast_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        state_q   <= BURST;
                        owner_q   <= pickWin;
                        beat_q    <= '0;
                        gnt_q     <= NUM_REQ'(1) << pickWin;
                        romAddr_q <= req_addr[pickWin*ROM_ADDR_W +: ROM_ADDR_W];
                    end
                end
                BURST: begin
                    gnt_q      <= '0;
                    rspValid_q <= NUM_REQ'(1) << owner_q;
                    rspLast_q  <= (beat_q == LAST_BEAT);
                    if (beat_q == LAST_BEAT) begin
                        state_q <= IDLE;
                    end else begin
                        beat_q    <= beat_q + 1'b1;
                        romAddr_q <= romAddr_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rom_addr  = romAddr_q;
    assign rsp_valid = rspValid_q;
    assign rsp_last  = rspLast_q;
    assign rsp_data  = rom_data;
    assign busy      = (state_q == BURST) || (|rspValid_q);

endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

- Shares one 256×16 sprite ROM (registered read, 1-cycle latency) between several pixel-pipeline requesters, e.g. one per slot reel.
- Each granted request becomes a fixed-length burst of consecutive ROM reads; read data is returned with a one-hot owner tag and a last-beat flag.
- Sits between the reel renderers and a single sprite ROM instance.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters (2..8)
- BURST_LEN, 16: words per burst, one 16-pixel sprite row (1..256)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  level request per requester; held until the matching gnt pulse
- req_addr  in  NUM_REQ*8  start address per requester, flattened, requester i at bits [8i+7:8i]
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- rom_addr  out  8  address to ROM, register-driven
- rom_data  in  16  ROM read data, valid one cycle after rom_addr
- rsp_valid  out  NUM_REQ  one-hot, marks a returned data beat for requester i
- rsp_data  out  16  returned pixel word, passed through from rom_data
- rsp_last  out  1  final beat of a burst, qualified by any rsp_valid
- busy  out  1  FSM is in BURST or data is still in flight

## Operation
- States: IDLE, BURST.
- IDLE:
  - req is sampled at the clock edge.
  - If any bit is set: pick a winner, latch its index and req_addr, clear the beat counter, go to BURST.
  - Otherwise stay in IDLE.
- Arbitration is round-robin. The search starts at last winner + 1, modulo NUM_REQ. The last-winner pointer resets to NUM_REQ-1, so requester 0 wins first.
- BURST:
  - rom_addr = base + beat, 8-bit wrap (0xFF+1 → 0x00).
  - beat counts 0..BURST_LEN-1.
  - On beat BURST_LEN-1, return to IDLE.
- gnt[winner] is high only in the first BURST cycle.
- Requester handshake:
  - The requester deasserts req before the FSM returns to IDLE.
  - A req still high in IDLE is a new request.
  - Changes to req_addr after gnt are ignored.
- Return pipeline, one register stage beside the ROM:
  - Holds beat-valid, owner index and last flag.
  - The next cycle drives rsp_valid[owner], rsp_last and rsp_data = rom_data.
- Requests from a non-winning requester stay pending and are not lost.
- Only IDLE samples requests, so arrivals during BURST wait.
- Reset value of every output is 0: gnt, rom_addr, rsp_valid, rsp_last, busy.
- Reset mid-burst:
  - FSM goes to IDLE, pointer returns to NUM_REQ-1, return pipeline clears.
  - No rsp_valid in the cycle after reset, even though the ROM still outputs data.

## Timing
- Cycle T: IDLE, req[i] sampled high.
- Cycles T+1..T+L, with L = BURST_LEN: BURST, gnt[i] at T+1, rom_addr = base..base+L-1.
- Cycles T+2..T+L+1: rsp_valid[i] high, rsp_data = word k in cycle T+2+k, rsp_last at T+L+1.
- Cycle T+L+1: FSM back in IDLE and sampling req. The next burst's first address is at T+L+2, so there is one bubble cycle per burst.
- Throughput: L words per L+1 cycles. Latency: 2 cycles from sampled req to first data.
- busy is high from T+1 through T+L+1 inclusive.

## Configuration
- SPRITE_FETCH_FIXED_PRIO_EN defined:
  - Fixed priority, lowest index wins.
  - Last-winner pointer is not implemented.
- SPRITE_FETCH_FIXED_PRIO_EN undefined (default): round-robin as above.
- Timing and the handshake are identical in both modes.

## Structure
- Package sprite_fetch_pkg holds:
  - localparams ROM_ADDR_W = 8, ROM_DATA_W = 16, ROM_DEPTH = 256
  - typedef enum fetch_state_t {IDLE, BURST}
- Sub-module sprite_rr_pick: combinational round-robin/fixed-priority winner selection from req and pointer; contains the macro switch.
- Top module holds the FSM, beat counter, address register and return pipeline.
- The ROM stays an external instance connected via rom_addr/rom_data.

## Test plan
- Single burst: req[1], addr 0x20, L = 16 → gnt[1] at T+1; rsp_valid[1] T+2..T+17; data = ROM[0x20..0x2F]; rsp_last at T+17 only.
- Wrap: addr 0xF8, L = 16 → rom_addr sequence 0xF8..0xFF, 0x00..0x07; data matches ROM.
- Contention: req = 3'b111 held high across bursts → grants in order 0, 1, 2, 0; each burst is L+1 cycles apart; no requester starves.
- Fixed priority (macro defined): req = 3'b110 then 3'b111 → grants 1, then 0; requester 2 waits until req[0] and req[1] drop.
- Reset mid-burst: assert reset at beat 5 → next cycle has all outputs 0 and no rsp_valid; after release, req[2] is served with a full 16-beat burst.
- Back-to-back same requester: req[0] held high → second gnt[0] exactly L+1 cycles after the first; its req_addr is re-latched.
